// File: rtl/nibble_pkg.sv
// nibble_pkg: shared definitions for the nibble source input stage.
//   NIB_W           - nibble width handed to the downstream inverter
//   DEB_CYCLES_DFLT - default number of stable cycles for a debounced change
//   nib_state_e     - offer FSM state encoding
package nibble_pkg;

   localparam int NIB_W           = 4;
   localparam int DEB_CYCLES_DFLT = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } nib_state_e;

   // Rising-edge detect on a debounced level against its registered copy.
   function automatic logic rise_evt(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: one-bit 2-flop synchroniser followed by a debouncer.
// The debounced level only flips after the synchronised input has differed
// from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
//   clk   in  - rising-edge clock
//   rst_n in  - synchronous active-low reset
//   raw   in  - raw asynchronous input
//   level out - synchronised, debounced level
module debounce_sync
   import nibble_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         stable  <= 1'b0;
         cnt     <= '0;
      end else begin
         // synchroniser stages
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // debounce stage: flip on the edge the count would reach DEB_CYCLES
         if (sync_p1 != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= ~stable;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign level = stable;

endmodule

// File: rtl/nibble_src.sv
// nibble_src: produces the 4-bit operand for the nibble inverter.
// Switches and buttons are synchronised and debounced; a load press captures
// the switches, an increment press adds one (wrapping), and the result is
// offered on a valid/ready handshake. Events arriving while an offer is
// pending (or colliding with a load) are discarded and flagged on evt_drop.
//   clk       in  - rising-edge clock
//   rst_n     in  - synchronous active-low reset
//   sw_in     in  - raw switch levels
//   btn_load  in  - raw load button, active-high
//   btn_inc   in  - raw increment button, active-high
//   nib_out   out - offered nibble (current value in every state)
//   nib_valid out - nib_out is being offered
//   nib_ready in  - downstream accepts nib_out
//   evt_drop  out - one-cycle pulse when a button event was discarded
module nibble_src
   import nibble_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DFLT,
   parameter int WIDTH      = NIB_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             btn_load,
   input  logic             btn_inc,
   output logic [WIDTH-1:0] nib_out,
   output logic             nib_valid,
   input  logic             nib_ready,
   output logic             evt_drop
);

   logic [WIDTH-1:0] sw_deb;
   logic             load_lvl;
   logic             inc_lvl;
   logic             load_prev;
   logic             inc_prev;
   logic             load_evt;
   logic             inc_evt;

   nib_state_e       state_q;
   nib_state_e       state_d;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic             drop_q;
   logic             drop_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_sw
      debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (sw_in[i]),
         .level (sw_deb[i])
      );
   end

   debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_load_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_load),
      .level (load_lvl)
   );

   debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_inc),
      .level (inc_lvl)
   );

   // One event per debounced press; releases produce nothing.
   assign load_evt = rise_evt(load_lvl, load_prev);
   assign inc_evt  = rise_evt(inc_lvl, inc_prev);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_prev <= 1'b0;
         inc_prev  <= 1'b0;
         state_q   <= IDLE;
         value_q   <= '0;
         drop_q    <= 1'b0;
      end else begin
         load_prev <= load_lvl;
         inc_prev  <= inc_lvl;
         state_q   <= state_d;
         value_q   <= value_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      drop_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_evt) begin
               // load has priority; a simultaneous inc is lost
               value_d = sw_deb;
               state_d = OFFER;
               drop_d  = inc_evt;
            end else if (inc_evt) begin
               value_d = value_q + WIDTH'(1);
               state_d = OFFER;
            end
         end
         OFFER: begin
            // no queueing: anything pressed during an offer is discarded,
            // including on the transfer edge itself
            drop_d = load_evt | inc_evt;
            if (nib_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign nib_out   = value_q;
   assign nib_valid = (state_q == OFFER);
   assign evt_drop  = drop_q;

endmodule
